// File: rtl/pixel2byte.sv
// Packs RAW10 pixel groups (4 pixels / 40 bits) into a 16-bit byte stream,
// padding each line end to a word boundary and dropping data before the first vsync.
module pixel2byte #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pixel_vsync,
    input  logic        pixel_vld,
    input  logic        pixel_eol,
    input  logic [39:0] pixel_data,
    output logic        pixel_rdy,
    output logic        raw_vsync,
    output logic        raw_vld,
    output logic [15:0] raw_data,
    input  logic        raw_rdy
);

    logic [7:0] byte_buf_q [8];
    logic [7:0] byte_buf_d [8];
    logic [3:0] byte_cnt_q, byte_cnt_d;
    logic       frame_valid_q, frame_valid_d;
    logic       raw_vsync_q, raw_vsync_d;

    logic [7:0] grp [8];
    logic [7:0] shifted [8];
    logic [3:0] base_cnt;
    logic [3:0] n_app;
    logic       accept, pop, keep, pad;
    int unsigned off;

    assign pixel_rdy = ~frame_valid_q | (byte_cnt_q <= 4'd3);
    assign raw_vld   = (byte_cnt_q >= 4'd2);
    assign raw_data  = {byte_buf_q[1], byte_buf_q[0]};
    assign raw_vsync = raw_vsync_q;

    always_comb begin
        grp[0] = pixel_data[39:32];
        grp[1] = pixel_data[29:22];
        grp[2] = pixel_data[19:12];
        grp[3] = pixel_data[9:2];
        grp[4] = {pixel_data[1:0], pixel_data[11:10], pixel_data[21:20], pixel_data[31:30]};
        grp[5] = PAD_BYTE;
        grp[6] = '0;
        grp[7] = '0;

        accept        = pixel_vld & pixel_rdy;
        pop           = raw_vld & raw_rdy;
        frame_valid_d = frame_valid_q | pixel_vsync;
        raw_vsync_d   = pixel_vsync;
        keep          = accept & frame_valid_d;

        // vsync flushes the buffer and wins over a pop in the same cycle
        if (pixel_vsync) begin
            base_cnt = '0;
        end else if (pop) begin
            base_cnt = byte_cnt_q - 4'd2;
        end else begin
            base_cnt = byte_cnt_q;
        end

        for (int unsigned i = 0; i < 6; i++) begin
            shifted[i] = (pop && !pixel_vsync) ? byte_buf_q[i + 2] : byte_buf_q[i];
        end
        shifted[6] = (pop && !pixel_vsync) ? 8'h00 : byte_buf_q[6];
        shifted[7] = (pop && !pixel_vsync) ? 8'h00 : byte_buf_q[7];

        // base+5 is odd exactly when base is even
        pad        = keep & pixel_eol & ~base_cnt[0];
        n_app      = keep ? (pad ? 4'd6 : 4'd5) : 4'd0;
        byte_cnt_d = base_cnt + n_app;

        off = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            off = i - 32'(base_cnt);
            if (off < 32'(n_app)) begin
                byte_buf_d[i] = grp[off[2:0]];
            end else begin
                byte_buf_d[i] = shifted[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 8; i++) begin
                byte_buf_q[i] <= '0;
            end
            byte_cnt_q    <= '0;
            frame_valid_q <= 1'b0;
            raw_vsync_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                byte_buf_q[i] <= byte_buf_d[i];
            end
            byte_cnt_q    <= byte_cnt_d;
            frame_valid_q <= frame_valid_d;
            raw_vsync_q   <= raw_vsync_d;
        end
    end

endmodule

// File: tb/tb_pixel2byte.sv
// Randomised and directed checks of pixel2byte against a byte-queue reference model.
module tb_pixel2byte;

    localparam logic [7:0] PAD = 8'hA5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pixel_vsync, pixel_vld, pixel_eol, raw_rdy;
    logic [39:0] pixel_data;
    logic        pixel_rdy, raw_vsync, raw_vld;
    logic [15:0] raw_data;

    pixel2byte #(.PAD_BYTE(PAD)) dut (
        .clk(clk), .resetn(resetn),
        .pixel_vsync(pixel_vsync), .pixel_vld(pixel_vld), .pixel_eol(pixel_eol),
        .pixel_data(pixel_data), .pixel_rdy(pixel_rdy),
        .raw_vsync(raw_vsync), .raw_vld(raw_vld), .raw_data(raw_data), .raw_rdy(raw_rdy)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  mq [$];
    logic [15:0] obs [$];
    logic        m_fv;
    logic        last_acc;
    int unsigned groups;

    localparam logic [39:0] G_A = {10'h3FF, 10'h000, 10'h155, 10'h2AA};
    localparam logic [39:0] G_B = {10'h123, 10'h2F0, 10'h00F, 10'h3C1};
    localparam logic [39:0] G_C = {10'h0AB, 10'h155, 10'h3FE, 10'h001};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_group(input logic [39:0] d);
        logic [9:0] p1, p2, p3, p4;
        p1 = d[39:30]; p2 = d[29:20]; p3 = d[19:10]; p4 = d[9:0];
        mq.push_back(p1[9:2]);
        mq.push_back(p2[9:2]);
        mq.push_back(p3[9:2]);
        mq.push_back(p4[9:2]);
        mq.push_back({p4[1:0], p3[1:0], p2[1:0], p1[1:0]});
    endtask

    task automatic model_compare(input logic vs);
        check("pixel_rdy", 16'(pixel_rdy), 16'(!m_fv || mq.size() <= 3));
        check("raw_vld", 16'(raw_vld), 16'(mq.size() >= 2));
        check("raw_vsync", 16'(raw_vsync), 16'(vs));
        if (mq.size() >= 2) check("raw_data", raw_data, {mq[1], mq[0]});
    endtask

    // Called at a negedge: drive, advance one clock, update model, compare at next negedge.
    task automatic step(input logic vs, input logic vld, input logic eol,
                        input logic [39:0] d, input logic rr);
        logic acc, pop;
        if (raw_vld && rr) obs.push_back(raw_data);
        pixel_vsync = vs; pixel_vld = vld; pixel_eol = eol; pixel_data = d; raw_rdy = rr;
        acc = vld && (!m_fv || mq.size() <= 3);
        pop = rr && mq.size() >= 2;
        @(posedge clk);
        if (vs) begin
            mq.delete();
            m_fv = 1'b1;
        end else if (pop) begin
            void'(mq.pop_front());
            void'(mq.pop_front());
        end
        last_acc = acc && m_fv;
        if (last_acc) begin
            push_group(d);
            if (eol && mq.size() % 2 == 1) mq.push_back(PAD);
            groups++;
        end
        @(negedge clk);
        model_compare(vs);
    endtask

    task automatic send_group(input logic vs, input logic eol, input logic [39:0] d, input logic rr);
        int unsigned tries = 0;
        last_acc = 1'b0;
        while (!last_acc && tries < 20) begin
            step(vs && tries == 0, 1'b1, eol, d, rr);
            tries++;
        end
        check("send_timeout", 16'(last_acc), 16'd1);
    endtask

    task automatic drain(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 40'h0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        mq.delete();
        m_fv = 1'b0;
        check("rst_pixel_rdy", 16'(pixel_rdy), 16'd1);
        check("rst_raw_vld", 16'(raw_vld), 16'd0);
        check("rst_raw_vsync", 16'(raw_vsync), 16'd0);
        check("rst_raw_data", raw_data, 16'h0000);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int unsigned cycles;
        resetn = 1'b0;
        pixel_vsync = 1'b0; pixel_vld = 1'b0; pixel_eol = 1'b0; pixel_data = '0; raw_rdy = 1'b0;
        m_fv = 1'b0; groups = 0; last_acc = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // single eol group: FF, 00, 55, AA, 93 then pad
        step(1'b1, 1'b0, 1'b0, 40'h0, 1'b1);
        obs.delete();
        send_group(1'b0, 1'b1, G_A, 1'b1);
        drain(4);
        check("single_words", 16'(obs.size()), 16'd3);
        if (obs.size() == 3) begin
            check("single_w0", obs[0], 16'h00FF);
            check("single_w1", obs[1], 16'hAA55);
            check("single_w2", obs[2], {PAD, 8'h93});
        end
        check("single_idle", 16'(raw_vld), 16'd0);

        // two groups without eol, then eol group: 5 words + 3 words
        obs.delete();
        send_group(1'b0, 1'b0, G_B, 1'b1);
        send_group(1'b0, 1'b0, G_C, 1'b1);
        send_group(1'b0, 1'b1, G_C, 1'b1);
        drain(6);
        check("two_words", 16'(obs.size()), 16'd8);
        if (obs.size() == 8) begin
            check("two_w2_hi", 16'(obs[2][15:8]), 16'(8'h2A));
            check("two_w7", obs[7], {PAD, 8'b01_10_01_11});
        end

        // backpressure: only one group fits, then rdy drops and data holds
        for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, G_A, 1'b0);
        check("bp_rdy", 16'(pixel_rdy), 16'd0);
        check("bp_data", raw_data, 16'h00FF);
        obs.delete();
        drain(3);
        check("bp_words", 16'(obs.size()), 16'd2);
        if (obs.size() == 2) check("bp_w1", obs[1], 16'hAA55);

        // residue of one byte dropped by vsync with coincident accept
        step(1'b1, 1'b1, 1'b0, G_B, 1'b0);
        check("vs_data", raw_data, 16'hBC48);
        step(1'b0, 1'b0, 1'b0, 40'h0, 1'b0);
        check("vs_pulse_end", 16'(raw_vsync), 16'd0);

        // mid-frame reset, then pre-vsync groups are discarded
        do_reset();
        for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, G_B, 1'b1);
        check("prevs_vld", 16'(raw_vld), 16'd0);
        step(1'b1, 1'b0, 1'b0, 40'h0, 1'b1);
        obs.delete();
        send_group(1'b0, 1'b1, G_A, 1'b1);
        drain(4);
        if (obs.size() > 0) check("prevs_w0", obs[0], 16'h00FF);
        else check("prevs_words", 16'(obs.size()), 16'd3);

        // random stream against the queue model
        groups = 0;
        cycles = 0;
        while (groups < 10000 && cycles < 90000) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) == 0), {8'($urandom), $urandom},
                 ($urandom_range(0, 9) < 7));
            cycles++;
        end
        check("rand_groups_done", 16'(groups >= 10000), 16'd1);
        drain(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel2byte.md
PIXEL2BYTE -- requirements
Module: pixel2byte

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'h00, the byte value inserted to word-align a line end.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pixel_vsync  input  1  frame-start pulse, one cycle.
REQ-005 SHALL have port pixel_vld  input  1  pixel group valid.
REQ-006 SHALL have port pixel_eol  input  1  current group is last of line; qualified by pixel_vld.
REQ-007 SHALL have port pixel_data  input  40  four RAW10 pixels {p1,p2,p3,p4}; p1 = [39:30], p4 = [9:0].
REQ-008 SHALL have port pixel_rdy  output  1  group accepted when pixel_vld and pixel_rdy are both high.
REQ-009 SHALL have port raw_vsync  output  1  frame-start pulse, registered.
REQ-010 SHALL have port raw_vld  output  1  raw_data holds a valid word.
REQ-011 SHALL have port raw_data  output  16  two packed bytes; [7:0] = earlier byte, [15:8] = later byte.
REQ-012 SHALL have port raw_rdy  input  1  word consumed when raw_vld and raw_rdy are both high.

Function
REQ-013 SHALL pack each accepted group into 5 bytes in this order:
  - byte0 = p1[9:2]
  - byte1 = p2[9:2]
  - byte2 = p3[9:2]
  - byte3 = p4[9:2]
  - byte4 = {p4[1:0], p3[1:0], p2[1:0], p1[1:0]}
REQ-014 SHALL hold bytes in an 8-byte in-order buffer with a count byte_cnt in the range 0..8.
REQ-015 SHALL drive pixel_rdy = (byte_cnt <= 3) combinationally, independent of raw_rdy.
REQ-016 SHALL drive raw_vld = (byte_cnt >= 2) and raw_data = {buffer[1], buffer[0]} combinationally from the buffer.
REQ-017 SHALL, on a pop, remove 2 bytes; on an accept, append 5 bytes behind the remaining bytes; pop and accept in the same cycle give byte_cnt + 5 - 2.
REQ-018 SHALL, on an accept with pixel_eol = 1 that leaves an odd byte count, append one PAD_BYTE after byte4, so every line ends word-aligned.
REQ-019 SHALL NOT pad when pixel_eol = 0 or when the resulting count is even; a half-word carries over into the next group.
REQ-020 SHALL keep frame_valid = 0 from reset until the first pixel_vsync; while frame_valid = 0, pixel_rdy = 1 and accepted groups are discarded without entering the buffer.
REQ-021 SHALL, on pixel_vsync:
  - set frame_valid = 1;
  - clear the buffer (byte_cnt = 0), discarding any residue from the previous frame;
  - treat a group accepted in the same cycle as the first group of the new frame (byte_cnt becomes 5 or 6);
  - give the vsync clear priority over any pop in that cycle.
REQ-022 SHALL register raw_vsync as pixel_vsync delayed by exactly 1 cycle.
REQ-023 SHALL give a latency of 1 cycle: a group accepted at edge N into an empty buffer shows raw_vld = 1 with its first word after edge N.
REQ-024 SHALL keep raw_data stable while raw_vld = 1 and raw_rdy = 0; the buffer never overflows, since the maximum count is 8.

Reset
REQ-025 SHALL, while resetn = 0, force: byte_cnt = 0, frame_valid = 0, raw_vld = 0, raw_vsync = 0, raw_data = 16'h0000, pixel_rdy = 1.
REQ-026 SHALL abandon any partially emitted group on a mid-frame reset; after release, no output appears until the next pixel_vsync.

Verification
REQ-027 SHALL cover single group, eol: vsync, then {10'h3FF, 10'h000, 10'h155, 10'h2AA} with eol and raw_rdy = 1 -> words 16'h00FF, 16'hAA55, 16'h0093 (pad high byte), then raw_vld = 0.
REQ-028 SHALL cover two groups, no eol, then the same group again as eol -> 5 words, then 3 words; the third word's high byte is the next group's p1[9:2], and the final word carries byte4 plus PAD_BYTE.
REQ-029 SHALL cover backpressure: raw_rdy = 0 with groups offered -> at most 1 group accepted (byte_cnt 5), then pixel_rdy = 0, raw_data held; on raw_rdy = 1 the words emerge with none lost or duplicated.
REQ-030 SHALL cover pre-vsync groups after reset: 3 groups sent -> pixel_rdy = 1, raw_vld = 0 throughout; after vsync the next group appears normally.
REQ-031 SHALL cover vsync with residue: byte_cnt = 1 and vsync coincident with an accept -> residue dropped, byte_cnt = 5, raw_vsync high exactly 1 cycle later.
REQ-032 SHALL cover a random stream against a reference model (random pixel_vld, pixel_eol, raw_rdy, 10 000 groups) -> byte stream matches the model exactly.
